// File: rtl/additionneur_sequentiel_pkg.sv
// Shared definitions for the sequential adder/subtractor: FSM state
// encoding and the slice-count helper used to size the slice index.
package additionneur_sequentiel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of CHUNK-bit slices needed to cover a WIDTH-bit operand.
   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Width of a counter that indexes nchunk slices (at least one bit).
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/additionneur_sequentiel_tranche.sv
// One CHUNK-bit ripple slice: s = a + b + rin, with carry-out on rout.
// Purely combinational; the top level registers the carry between slices.
module additionneur_tranche #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             rin,
   output logic [CHUNK-1:0] s,
   output logic             rout
);

   // Widen by one bit so the carry-out falls out of the addition.
   assign {rout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, rin};

endmodule

// File: rtl/additionneur_sequentiel.sv
// Multi-cycle adder/subtractor with accumulate mode. A WIDTH-bit operation
// runs through one CHUNK-bit slice, LSB first, one slice per clock, with a
// registered carry linking consecutive slices.
module additionneur_sequentiel
   import additionneur_sequentiel_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic             acc_mode,
   input  logic             clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             rout,
   output logic             ovf
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int KW     = index_width(NCHUNK);
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [KW-1:0]    k;

   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_s;
   logic             slice_c;
   int               base;

   // Select the operand slice addressed by the current slice index.
   always_comb begin
      base    = int'(k) * CHUNK;
      slice_a = op_a[base +: CHUNK];
      slice_b = op_b[base +: CHUNK];
   end

   additionneur_tranche #(
      .CHUNK (CHUNK)
   ) u_tranche (
      .a    (slice_a),
      .b    (slice_b),
      .rin  (carry),
      .s    (slice_s),
      .rout (slice_c)
   );

   // FSM, operand/carry registers and result register in one clocked process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand registers are reset too, so nothing in the datapath
         // ever carries X out of reset even though they are only read in RUN.
         state <= ST_IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
         s     <= '0;
         rout  <= 1'b0;
         ovf   <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         k     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Clear is applied before a same-cycle start, so an
               // accumulating start after clr sees op_a = 0.
               if (clr) begin
                  s    <= '0;
                  rout <= 1'b0;
                  ovf  <= 1'b0;
               end
               if (start) begin
                  // NOTE: non-blocking assignments keep the old s visible to
                  // the op_a mux in this same cycle; clr is folded in by hand.
                  op_a  <= acc_mode ? (clr ? '0 : s) : a;
                  op_b  <= op_sub ? ~b : b;
                  carry <= op_sub | rin;
                  k     <= '0;
                  ready <= 1'b0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               s[base +: CHUNK] <= slice_s;
               carry            <= slice_c;
               if (k == K_LAST) begin
                  // The slice being written holds the result MSB, so the
                  // flags are taken from the slice output directly.
                  rout  <= slice_c;
                  ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                           (slice_s[CHUNK-1] != op_a[WIDTH-1]);
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_additionneur_sequentiel.sv
// Scoreboard bench for additionneur_sequentiel: four instances cover the
// 16/8, 32/8, 16/16 and 8/1 configurations. The driver pushes expected
// results computed with plain wide arithmetic; a monitor pops them on done.
module tb_additionneur_sequentiel;

   localparam int NDUT = 4;

   typedef struct {
      logic [31:0] s;
      logic        rout;
      logic        ovf;
      longint      acc_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_sub, acc_mode, rin;
   logic [31:0] a_bus, b_bus;
   logic        start_v [NDUT];
   logic        clr_v   [NDUT];
   logic        rdy_v   [NDUT];
   logic        done_v  [NDUT];
   logic        rout_v  [NDUT];
   logic        ovf_v   [NDUT];
   logic [31:0] s_v     [NDUT];
   logic [15:0] s0;
   logic [31:0] s1;
   logic [15:0] s2;
   logic [7:0]  s3;

   int          width_of [NDUT] = '{16, 32, 16, 8};
   int          nch_of   [NDUT] = '{2, 4, 1, 8};
   logic [31:0] model_s  [NDUT];
   exp_t        q [NDUT][$];
   longint      cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   additionneur_sequentiel #(.WIDTH(16), .CHUNK(8)) u_w16c8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_sub(op_sub),
      .acc_mode(acc_mode), .clr(clr_v[0]), .a(a_bus[15:0]), .b(b_bus[15:0]),
      .rin(rin), .ready(rdy_v[0]), .done(done_v[0]), .s(s0),
      .rout(rout_v[0]), .ovf(ovf_v[0]));

   additionneur_sequentiel #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_sub(op_sub),
      .acc_mode(acc_mode), .clr(clr_v[1]), .a(a_bus), .b(b_bus),
      .rin(rin), .ready(rdy_v[1]), .done(done_v[1]), .s(s1),
      .rout(rout_v[1]), .ovf(ovf_v[1]));

   additionneur_sequentiel #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op_sub(op_sub),
      .acc_mode(acc_mode), .clr(clr_v[2]), .a(a_bus[15:0]), .b(b_bus[15:0]),
      .rin(rin), .ready(rdy_v[2]), .done(done_v[2]), .s(s2),
      .rout(rout_v[2]), .ovf(ovf_v[2]));

   additionneur_sequentiel #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .op_sub(op_sub),
      .acc_mode(acc_mode), .clr(clr_v[3]), .a(a_bus[7:0]), .b(b_bus[7:0]),
      .rin(rin), .ready(rdy_v[3]), .done(done_v[3]), .s(s3),
      .rout(rout_v[3]), .ovf(ovf_v[3]));

   assign s_v[0] = {16'd0, s0};
   assign s_v[1] = s1;
   assign s_v[2] = {16'd0, s2};
   assign s_v[3] = {24'd0, s3};

   task automatic check(input string name, input int id,
                        input logic [63:0] got, input logic [63:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)",
                  name, id, got, expv, $time);
      end
   endtask

   // Reference: arithmetic modulo 2^w with the carry read from bit w, and
   // signed overflow from the sign bits of the effective operands.
   function automatic exp_t model(input int w, input logic [31:0] opa,
                                  input logic [31:0] bv, input bit sub,
                                  input bit rv);
      exp_t r;
      longint unsigned mask, ea, eb, full;
      bit sa, sb, ss;
      mask = (64'd1 << w) - 1;
      ea   = 64'(opa) & mask;
      eb   = sub ? (~64'(bv) & mask) : (64'(bv) & mask);
      full = ea + eb + (sub ? 64'd1 : 64'(rv));
      sa   = ea[w-1];
      sb   = eb[w-1];
      ss   = full[w-1];
      r.s       = 32'(full & mask);
      r.rout    = full[w];
      r.ovf     = (sa == sb) && (ss != sa);
      r.acc_cyc = 0;
      return r;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NDUT; i++) begin
            if (done_v[i]) begin
               if (q[i].size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_done dut%0d: got done=1, expected no pulse (t=%0t)",
                           i, $time);
               end else begin
                  exp_t e;
                  e = q[i].pop_front();
                  check("result_s", i, 64'(s_v[i]), 64'(e.s));
                  check("rout", i, 64'(rout_v[i]), 64'(e.rout));
                  check("ovf", i, 64'(ovf_v[i]), 64'(e.ovf));
                  check("latency", i, 64'(cyc - e.acc_cyc + 1), 64'(nch_of[i] + 1));
                  check("ready_low_at_done", i, 64'(rdy_v[i]), 64'd0);
               end
            end
         end
      end
   end

   task automatic wait_ready(input int id, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (rdy_v[id]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL ready_timeout dut%0d: got ready=0, expected 1 within 500 cycles", id);
      end
   endtask

   task automatic issue(input int id, input bit sub, input bit acc,
                        input bit clr, input logic [31:0] av,
                        input logic [31:0] bv, input bit rv, input bit ghost);
      bit          ok;
      exp_t        e;
      logic [31:0] opa;
      longint unsigned mask;
      wait_ready(id, ok);
      if (!ok) return;
      op_sub      = sub;
      acc_mode    = acc;
      a_bus       = av;
      b_bus       = bv;
      rin         = rv;
      start_v[id] = 1'b1;
      clr_v[id]   = clr;
      if (clr) model_s[id] = '0;
      mask = (64'd1 << width_of[id]) - 1;
      opa  = acc ? model_s[id] : 32'(64'(av) & mask);
      e    = model(width_of[id], opa, bv, sub, rv);
      e.acc_cyc = cyc + 1;
      q[id].push_back(e);
      model_s[id] = e.s;
      @(negedge clk);
      start_v[id] = 1'b0;
      clr_v[id]   = 1'b0;
      if (ghost) begin
         start_v[id] = 1'b1;
         a_bus       = $urandom;
         @(negedge clk);
         start_v[id] = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      for (int i = 0; i < 500; i++) begin
         n = 0;
         for (int d = 0; d < NDUT; d++) n += q[d].size();
         if (n == 0) return;
         @(negedge clk);
      end
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d outstanding results, expected 0", n);
   endtask

   initial begin
      bit ok;
      rst_n    = 1'b0;
      op_sub   = 1'b0;
      acc_mode = 1'b0;
      rin      = 1'b0;
      a_bus    = '0;
      b_bus    = '0;
      for (int d = 0; d < NDUT; d++) begin
         start_v[d] = 1'b0;
         clr_v[d]   = 1'b0;
         model_s[d] = '0;
      end
      repeat (3) @(negedge clk);

      for (int d = 0; d < NDUT; d++) begin
         check("reset_ready", d, 64'(rdy_v[d]), 64'd1);
         check("reset_done", d, 64'(done_v[d]), 64'd0);
         check("reset_s", d, 64'(s_v[d]), 64'd0);
         check("reset_rout", d, 64'(rout_v[d]), 64'd0);
         check("reset_ovf", d, 64'(ovf_v[d]), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases on the 16/8 instance.
      issue(0, 0, 0, 0, 32'h00FF, 32'h0001, 0, 0);
      issue(0, 0, 0, 0, 32'hFFFF, 32'h0001, 0, 0);
      issue(0, 0, 0, 0, 32'h7FFF, 32'h0001, 0, 0);
      issue(0, 1, 0, 0, 32'h0005, 32'h0007, 1, 0);
      issue(0, 1, 0, 0, 32'h8000, 32'h0001, 0, 0);
      issue(0, 0, 1, 1, 32'hABCD, 32'd10, 0, 0);
      issue(0, 0, 1, 0, 32'h5555, 32'd20, 0, 1);
      issue(0, 0, 1, 0, 32'h0F0F, 32'd30, 0, 1);
      issue(0, 0, 0, 0, 32'h7FFF, 32'h0001, 0, 0);
      drain();

      // clr alone wipes s and the flags without a done pulse.
      wait_ready(0, ok);
      clr_v[0]   = 1'b1;
      model_s[0] = '0;
      @(negedge clk);
      clr_v[0] = 1'b0;
      check("clr_s", 0, 64'(s_v[0]), 64'd0);
      check("clr_rout", 0, 64'(rout_v[0]), 64'd0);
      check("clr_ovf", 0, 64'(ovf_v[0]), 64'd0);
      check("clr_ready", 0, 64'(rdy_v[0]), 64'd1);

      // Reset one cycle after accept aborts the operation immediately.
      issue(0, 0, 0, 0, 32'h4444, 32'h3333, 0, 0);
      rst_n = 1'b0;
      #1;
      check("abort_s", 0, 64'(s_v[0]), 64'd0);
      check("abort_ready", 0, 64'(rdy_v[0]), 64'd1);
      check("abort_done", 0, 64'(done_v[0]), 64'd0);
      for (int d = 0; d < NDUT; d++) begin
         q[d].delete();
         model_s[d] = '0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 0, 0, 0, 32'h1234, 32'h1111, 0, 0);
      drain();

      // Randomised operations on every configuration.
      for (int d = 0; d < NDUT; d++) begin
         for (int n = 0; n < 40; n++) begin
            issue(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), $urandom, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
         end
         drain();
      end

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
